// File: rtl/l2_mem_pkg.sv
// Shared types for the L2 bank arbiter: request owner tag and the request payload struct.
// Widths here match the default cut geometry (14-bit word address, 64-bit data).
package l2_mem_pkg;

    localparam int L2_ADDR_WIDTH = 14;
    localparam int L2_DATA_WIDTH = 64;
    localparam int L2_BE_WIDTH   = L2_DATA_WIDTH / 8;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic [L2_ADDR_WIDTH-1:0] addr;
        logic                     we;
        logic [L2_DATA_WIDTH-1:0] wdata;
        logic [L2_BE_WIDTH-1:0]   be;
    } bank_req_t;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_A) ? OWNER_B : OWNER_A;
    endfunction

endpackage

// File: rtl/l2_bank_arb_if.sv
// Two requester ports plus the single-ported cut side of the L2 bank arbiter.
// slave = arbiter view, master = requesters and cut view.
interface l2_bank_arb_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  a_req_i;
    logic                  a_gnt_o;
    logic [ADDR_WIDTH-1:0] a_addr_i;
    logic                  a_we_i;
    logic [DATA_WIDTH-1:0] a_wdata_i;
    logic [BE_WIDTH-1:0]   a_be_i;
    logic                  a_rvalid_o;
    logic [DATA_WIDTH-1:0] a_rdata_o;

    logic                  b_req_i;
    logic                  b_gnt_o;
    logic [ADDR_WIDTH-1:0] b_addr_i;
    logic                  b_we_i;
    logic [DATA_WIDTH-1:0] b_wdata_i;
    logic [BE_WIDTH-1:0]   b_be_i;
    logic                  b_rvalid_o;
    logic [DATA_WIDTH-1:0] b_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  a_req_i, a_addr_i, a_we_i, a_wdata_i, a_be_i,
        output a_gnt_o, a_rvalid_o, a_rdata_o,
        input  b_req_i, b_addr_i, b_we_i, b_wdata_i, b_be_i,
        output b_gnt_o, b_rvalid_o, b_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_rdata_i
    );

    modport master (
        output a_req_i, a_addr_i, a_we_i, a_wdata_i, a_be_i,
        input  a_gnt_o, a_rvalid_o, a_rdata_o,
        output b_req_i, b_addr_i, b_we_i, b_wdata_i, b_be_i,
        input  b_gnt_o, b_rvalid_o, b_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/l2_bank_resp_tracker.sv
// Tracks granted cut accesses: a DEPTH-stage {valid, owner, is_read} shift register.
// Latency DEPTH cycles from push to output; no backpressure, one push per cycle.
module l2_bank_resp_tracker
    import l2_mem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  owner_e owner_i,
    input  logic   is_read_i,
    output logic   valid_o,
    output owner_e owner_o,
    output logic   is_read_o
);

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
    } slot_t;

    slot_t [DEPTH-1:0] pipe_q;
    slot_t [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        // Idle slots are kept all-zero so downstream muxes never see stale tags.
        pipe_d[0] = push_i ? slot_t'{valid: 1'b1, owner: owner_i, is_read: is_read_i} : slot_t'('0);
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o   = pipe_q[DEPTH-1].valid;
    assign owner_o   = pipe_q[DEPTH-1].owner;
    assign is_read_o = pipe_q[DEPTH-1].is_read;

endmodule

// File: rtl/l2_bank_arb.sv
// Round-robin merge of two bank request ports onto one single-ported L2 cut; optional
// stall counters under L2_BANK_ARB_PERF_EN. Grant is combinational, responses return
// MEM_LATENCY cycles after grant in grant order; a losing port is simply not granted.
module l2_bank_arb
    import l2_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = L2_ADDR_WIDTH,
    parameter int DATA_WIDTH  = L2_DATA_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    l2_bank_arb_if.slave  bus,
    output logic [31:0]   a_stall_cnt_o,
    output logic [31:0]   b_stall_cnt_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    owner_e    rr_q;
    owner_e    rr_d;
    logic      sel_b;
    logic      any_req;
    bank_req_t a_req_s;
    bank_req_t b_req_s;
    bank_req_t win_s;

    logic      trk_valid;
    owner_e    trk_owner;
    logic      trk_is_read;
    logic [DATA_WIDTH-1:0] resp_data;

    always_comb begin
        a_req_s = '{addr:  L2_ADDR_WIDTH'(bus.a_addr_i),
                    we:    bus.a_we_i,
                    wdata: L2_DATA_WIDTH'(bus.a_wdata_i),
                    be:    L2_BE_WIDTH'(bus.a_be_i)};
        b_req_s = '{addr:  L2_ADDR_WIDTH'(bus.b_addr_i),
                    we:    bus.b_we_i,
                    wdata: L2_DATA_WIDTH'(bus.b_wdata_i),
                    be:    L2_BE_WIDTH'(bus.b_be_i)};

        any_req = bus.a_req_i | bus.b_req_i;
        // B wins when alone, or when contending and it holds the round-robin token.
        sel_b   = bus.b_req_i & (~bus.a_req_i | (rr_q == OWNER_B));

        rr_d = rr_q;
        if (bus.a_req_i && bus.b_req_i) begin
            rr_d = other_owner(rr_q);
        end

        win_s = '0;
        if (sel_b) begin
            win_s = b_req_s;
        end else if (bus.a_req_i) begin
            win_s = a_req_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= OWNER_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign bus.a_gnt_o     = bus.a_req_i & ~sel_b;
    assign bus.b_gnt_o     = sel_b;
    assign bus.mem_req_o   = any_req;
    assign bus.mem_we_o    = win_s.we;
    assign bus.mem_addr_o  = ADDR_WIDTH'(win_s.addr);
    assign bus.mem_wdata_o = DATA_WIDTH'(win_s.wdata);
    assign bus.mem_be_o    = BE_WIDTH'(win_s.be);

    l2_bank_resp_tracker #(
        .DEPTH (MEM_LATENCY)
    ) u_tracker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (any_req),
        .owner_i   (sel_b ? OWNER_B : OWNER_A),
        .is_read_i (~win_s.we),
        .valid_o   (trk_valid),
        .owner_o   (trk_owner),
        .is_read_o (trk_is_read)
    );

    // Writes still produce an rvalid pulse, but with zero data.
    assign resp_data      = trk_is_read ? bus.mem_rdata_i : '0;
    assign bus.a_rvalid_o = trk_valid & (trk_owner == OWNER_A);
    assign bus.b_rvalid_o = trk_valid & (trk_owner == OWNER_B);
    assign bus.a_rdata_o  = bus.a_rvalid_o ? resp_data : '0;
    assign bus.b_rdata_o  = bus.b_rvalid_o ? resp_data : '0;

`ifdef L2_BANK_ARB_PERF_EN
    logic [31:0] a_stall_q;
    logic [31:0] a_stall_d;
    logic [31:0] b_stall_q;
    logic [31:0] b_stall_d;

    always_comb begin
        a_stall_d = a_stall_q;
        b_stall_d = b_stall_q;
        if (bus.a_req_i && !bus.a_gnt_o && (a_stall_q != 32'hFFFF_FFFF)) begin
            a_stall_d = a_stall_q + 32'd1;
        end
        if (bus.b_req_i && !bus.b_gnt_o && (b_stall_q != 32'hFFFF_FFFF)) begin
            b_stall_d = b_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_stall_q <= '0;
            b_stall_q <= '0;
        end else begin
            a_stall_q <= a_stall_d;
            b_stall_q <= b_stall_d;
        end
    end

    assign a_stall_cnt_o = a_stall_q;
    assign b_stall_cnt_o = b_stall_q;
`else
    assign a_stall_cnt_o = '0;
    assign b_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_l2_bank_arb.sv
// Directed bench for l2_bank_arb: two instances (MEM_LATENCY 1 and 3) share one stimulus
// stream; each has its own cut model and response scoreboard queue.
module tb_l2_bank_arb;
    import l2_mem_pkg::*;

    localparam int AW = 14;
    localparam int DW = 64;
    localparam int BW = 8;

    typedef struct {
        bit          owner;
        bit [DW-1:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic [BW-1:0] a_be, b_be;
    logic [31:0]   a_st1, b_st1, a_st3, b_st3;

    l2_bank_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    l2_bank_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    assign bus1.a_req_i = a_req;  assign bus3.a_req_i = a_req;
    assign bus1.a_we_i = a_we;    assign bus3.a_we_i = a_we;
    assign bus1.a_addr_i = a_addr;  assign bus3.a_addr_i = a_addr;
    assign bus1.a_wdata_i = a_wdata; assign bus3.a_wdata_i = a_wdata;
    assign bus1.a_be_i = a_be;    assign bus3.a_be_i = a_be;
    assign bus1.b_req_i = b_req;  assign bus3.b_req_i = b_req;
    assign bus1.b_we_i = b_we;    assign bus3.b_we_i = b_we;
    assign bus1.b_addr_i = b_addr;  assign bus3.b_addr_i = b_addr;
    assign bus1.b_wdata_i = b_wdata; assign bus3.b_wdata_i = b_wdata;
    assign bus1.b_be_i = b_be;    assign bus3.b_be_i = b_be;

    l2_bank_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave), .a_stall_cnt_o(a_st1), .b_stall_cnt_o(b_st1));
    l2_bank_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave), .a_stall_cnt_o(a_st3), .b_stall_cnt_o(b_st3));

    function automatic bit [DW-1:0] merge(input bit [DW-1:0] old, input bit [DW-1:0] wd, input bit [BW-1:0] be);
        bit [DW-1:0] r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Zero-initialised cut models with fixed read latency.
    bit [DW-1:0] cut1 [0:(1<<AW)-1];
    bit [DW-1:0] cut3 [0:(1<<AW)-1];
    bit [DW-1:0] pipe1 [0:0];
    bit [DW-1:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (bus1.mem_req_o && bus1.mem_we_o)
            cut1[bus1.mem_addr_o] <= merge(cut1[bus1.mem_addr_o], bus1.mem_wdata_o, bus1.mem_be_o);
        pipe1[0] <= (bus1.mem_req_o && !bus1.mem_we_o) ? cut1[bus1.mem_addr_o] : '0;
        if (bus3.mem_req_o && bus3.mem_we_o)
            cut3[bus3.mem_addr_o] <= merge(cut3[bus3.mem_addr_o], bus3.mem_wdata_o, bus3.mem_be_o);
        pipe3[0] <= (bus3.mem_req_o && !bus3.mem_we_o) ? cut3[bus3.mem_addr_o] : '0;
        for (int i = 1; i < 3; i++) pipe3[i] <= pipe3[i-1];
    end
    assign bus1.mem_rdata_i = pipe1[0];
    assign bus3.mem_rdata_i = pipe3[2];

    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    exp_t q1[$];
    exp_t q3[$];
    bit   rr_m = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string p, input logic ga, gb, rq, we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input logic [BW-1:0] be,
                           input bit ega, egb, erq, ewe, input bit [AW-1:0] ead,
                           input bit [DW-1:0] ewd, input bit [BW-1:0] ebe);
        check({p, "_a_gnt"}, 64'(ga), 64'(ega));
        check({p, "_b_gnt"}, 64'(gb), 64'(egb));
        check({p, "_mem_req"}, 64'(rq), 64'(erq));
        check({p, "_mem_we"}, 64'(we), 64'(ewe));
        check({p, "_mem_addr"}, 64'(ad), 64'(ead));
        check({p, "_mem_wdata"}, wd, ewd);
        check({p, "_mem_be"}, 64'(be), 64'(ebe));
    endtask

    // Drive one cycle of requests (caller is at a negedge), check grant/cut side, push expectations.
    task automatic step(input bit ar, aw, input bit [AW-1:0] aa, input bit [DW-1:0] ad, input bit [BW-1:0] abe,
                        input bit br, bw, input bit [AW-1:0] ba, input bit [DW-1:0] bd, input bit [BW-1:0] bbe,
                        output bit ga, output bit gb);
        bit          ewe;
        bit [AW-1:0] ead;
        bit [DW-1:0] ewd;
        bit [BW-1:0] ebe;
        exp_t        e;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad; a_be = abe;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_be = bbe;
        gb = br && (!ar || rr_m);
        ga = ar && !gb;
        {ewe, ead, ewd, ebe} = '0;
        if (gb) {ewe, ead, ewd, ebe} = {bw, ba, bd, bbe};
        else if (ga) {ewe, ead, ewd, ebe} = {aw, aa, ad, abe};
        #1;
        chk_req("lat1", bus1.a_gnt_o, bus1.b_gnt_o, bus1.mem_req_o, bus1.mem_we_o, bus1.mem_addr_o,
                bus1.mem_wdata_o, bus1.mem_be_o, ga, gb, ga || gb, ewe, ead, ewd, ebe);
        chk_req("lat3", bus3.a_gnt_o, bus3.b_gnt_o, bus3.mem_req_o, bus3.mem_we_o, bus3.mem_addr_o,
                bus3.mem_wdata_o, bus3.mem_be_o, ga, gb, ga || gb, ewe, ead, ewd, ebe);
        if (ga || gb) begin
            e.owner = gb;
            if (ewe) begin
                ref_mem[ead] = merge(ref_mem[ead], ewd, ebe);
                e.data = '0;
            end else begin
                e.data = ref_mem[ead];
            end
            e.due = cyc + 1; q1.push_back(e);
            e.due = cyc + 3; q3.push_back(e);
        end
        if (ar && br) rr_m = !rr_m;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit ga, gb;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, ga, gb);
    endtask

    task automatic resp_check(input int lat, input logic av, bv, input logic [DW-1:0] ad, bd);
        exp_t h;
        bit   hit = 0;
        if (lat == 1) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin h = q1.pop_front(); hit = 1; end
        end else begin
            if (q3.size() > 0 && q3[0].due == cyc) begin h = q3.pop_front(); hit = 1; end
        end
        check($sformatf("lat%0d_a_rvalid@%0d", lat, cyc), 64'(av), 64'(hit && !h.owner));
        check($sformatf("lat%0d_b_rvalid@%0d", lat, cyc), 64'(bv), 64'(hit && h.owner));
        check($sformatf("lat%0d_a_rdata@%0d", lat, cyc), ad, (hit && !h.owner) ? h.data : '0);
        check($sformatf("lat%0d_b_rdata@%0d", lat, cyc), bd, (hit && h.owner) ? h.data : '0);
    endtask

    always @(negedge clk) begin
        resp_check(1, bus1.a_rvalid_o, bus1.b_rvalid_o, bus1.a_rdata_o, bus1.b_rdata_o);
        resp_check(3, bus3.a_rvalid_o, bus3.b_rvalid_o, bus3.a_rdata_o, bus3.b_rdata_o);
    end

    initial begin
        bit ga, gb;
        bit [AW-1:0] alist [0:2];
        bit [AW-1:0] blist [0:2];
        int ai, bi;
        logic [31:0] exp_stall;
`ifdef L2_BANK_ARB_PERF_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        rst_n = 1'b0;
        {a_req, a_we, a_addr, a_wdata, a_be} = '0;
        {b_req, b_we, b_addr, b_wdata, b_be} = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_lat1_mem_req", 64'(bus1.mem_req_o), 64'd0);
        check("rst_lat3_mem_addr", 64'(bus3.mem_addr_o), 64'd0);
        check("rst_lat1_a_stall", 64'(a_st1), 64'd0);
        check("rst_lat3_b_stall", 64'(b_st3), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        idle(2);

        // A writes three words (one partial), then reads them back-to-back.
        step(1, 1, 14'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, '0, '0, '0, ga, gb);
        step(1, 1, 14'h11, 64'hFEDC_BA98_7654_3210, 8'hF0, 0, 0, '0, '0, '0, ga, gb);
        step(1, 1, 14'h12, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, 0, '0, '0, '0, ga, gb);
        step(1, 0, 14'h10, '0, '0, 0, 0, '0, '0, '0, ga, gb);
        step(1, 0, 14'h11, '0, '0, 0, 0, '0, '0, '0, ga, gb);
        step(1, 0, 14'h12, '0, '0, 0, 0, '0, '0, '0, ga, gb);
        idle(4);

        // Partial write by A, read-back by B.
        step(1, 1, 14'h20, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 0, 0, '0, '0, '0, ga, gb);
        step(0, 0, '0, '0, '0, 1, 0, 14'h20, '0, '0, ga, gb);
        idle(4);

        // Both ports contend for 6 cycles; a loser holds its request.
        alist[0] = 14'h10; alist[1] = 14'h11; alist[2] = 14'h12;
        blist[0] = 14'h20; blist[1] = 14'h12; blist[2] = 14'h11;
        ai = 0; bi = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, alist[ai % 3], '0, '0, 1, 0, blist[bi % 3], '0, '0, ga, gb);
            if (ga) ai++;
            if (gb) bi++;
        end
        idle(4);

        // Leave the token on B, put two reads in flight, then reset.
        step(1, 0, 14'h10, '0, '0, 1, 0, 14'h11, '0, '0, ga, gb);
        step(0, 0, '0, '0, '0, 1, 0, 14'h11, '0, '0, ga, gb);
        #2;
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        q1.delete(); q3.delete();
        rr_m = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        idle(5);

        // 10 contended cycles from reset: first grant to A, each side stalls 5 times.
        ai = 0; bi = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, alist[ai % 3], '0, '0, 1, 0, blist[bi % 3], '0, '0, ga, gb);
            if (ga) ai++;
            if (gb) bi++;
        end
        a_req = 1'b0; b_req = 1'b0;
        #1;
        check("stall_lat1_a", 64'(a_st1), 64'(exp_stall));
        check("stall_lat1_b", 64'(b_st1), 64'(exp_stall));
        check("stall_lat3_a", 64'(a_st3), 64'(exp_stall));
        check("stall_lat3_b", 64'(b_st3), 64'(exp_stall));
        @(negedge clk);
        idle(5);
        check("lat1_queue_drained", 64'(q1.size()), 64'd0);
        check("lat3_queue_drained", 64'(q3.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
